// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline: trap flush window,
// solo-instruction drain FSM and a sticky stall watchdog.
module pipeline_hazard_ctrl #(
    parameter int CORE              = 0,
    parameter int NUM_STAGES        = 7,
    parameter int SOLO_STAGE        = 2,
    parameter int TRAP_FLUSH_CYCLES = 2,
    parameter int WDOG_WIDTH        = 16,
    parameter int WDOG_LIMIT        = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  trap_req,
    input  logic                  solo_req,
    input  logic                  clog,
    input  logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic [1:0]            state,
    output logic                  stall_timeout
);

    localparam int TW = (TRAP_FLUSH_CYCLES > 1) ? $clog2(TRAP_FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TRAP_FLUSH = 2'd1,
        SOLO_DRAIN = 2'd2,
        SOLO_PASS  = 2'd3
    } state_e;

    if (CORE < 0 || SOLO_STAGE < 0 || SOLO_STAGE >= NUM_STAGES - 1 || TRAP_FLUSH_CYCLES < 1)
    begin : g_param_check
        $error("pipeline_hazard_ctrl: illegal parameter combination");
    end

    state_e                  state_q, state_d;
    logic [TW-1:0]           trap_cnt_q, trap_cnt_d;
    logic [WDOG_WIDTH-1:0]   wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;

    logic                    older_valid_c;
    logic                    solo_hold_c;
    logic                    trap_active_c;
    logic                    stall_acc;
    logic                    redir_acc;
    logic [NUM_STAGES-1:0]   base_stall;
    logic [NUM_STAGES-1:0]   base_flush;
    logic [NUM_STAGES-1:0]   redir_mask;

    // Any valid instruction older than the solo slot blocks it from issuing.
    always_comb begin
        older_valid_c = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (j > SOLO_STAGE) older_valid_c = older_valid_c | stage_valid[j];
        end
    end

    assign solo_hold_c   = older_valid_c &&
                           (state_q == SOLO_DRAIN || (state_q == IDLE && solo_req));
    assign trap_active_c = trap_req || (state_q == TRAP_FLUSH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            trap_cnt_q <= '0;
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            trap_cnt_q <= trap_cnt_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state; a trap (re)loads the window and aborts any solo sequence.
    always_comb begin
        state_d    = state_q;
        trap_cnt_d = trap_cnt_q;
        if (trap_req) begin
            if (TRAP_FLUSH_CYCLES > 1) begin
                state_d    = TRAP_FLUSH;
                trap_cnt_d = TW'(TRAP_FLUSH_CYCLES - 1);
            end else begin
                state_d    = IDLE;
                trap_cnt_d = '0;
            end
        end else if (state_q == TRAP_FLUSH) begin
            trap_cnt_d = trap_cnt_q - TW'(1);
            if (trap_cnt_q == TW'(1)) state_d = IDLE;
        end else if (!clog) begin
            case (state_q)
                IDLE:       if (solo_req) state_d = older_valid_c ? SOLO_DRAIN : SOLO_PASS;
                SOLO_DRAIN: if (!older_valid_c) state_d = SOLO_PASS;
                SOLO_PASS:  state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end

        // Watchdog keeps running through clog so a frozen core is still caught.
        if (stall[0]) begin
            wdog_d = (wdog_q == WDOG_WIDTH'(WDOG_LIMIT)) ? wdog_q : wdog_q + WDOG_WIDTH'(1);
        end else begin
            wdog_d = '0;
        end
        timeout_d = timeout_q | (wdog_d == WDOG_WIDTH'(WDOG_LIMIT));
    end

    // Stall/flush vectors, combinational from requests and registered state.
    always_comb begin
        base_stall = '0;
        base_flush = '0;
        redir_mask = '0;
        stall_acc  = 1'b0;
        redir_acc  = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            stall_acc     = stall_acc | stall_req[k];
            base_stall[k] = stall_acc | (solo_hold_c && (k <= SOLO_STAGE));
        end
        for (int k = 0; k < NUM_STAGES - 1; k++) begin
            base_flush[k+1] = base_stall[k] & ~base_stall[k+1];
        end
        // A redirect only wins where its own stage is free to move.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            redir_acc     = redir_acc | (flush_req[k] & ~base_stall[k]);
            redir_mask[k] = redir_acc;
        end

        if (reset) begin
            stall = '0;
            flush = '0;
        end else if (trap_active_c) begin
            stall = '0;
            flush = '1;
        end else if (clog) begin
            stall = '1;
            flush = '0;
        end else begin
            stall = base_stall & ~redir_mask;
            flush = base_flush | redir_mask;
        end
    end

    assign state         = state_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (7 stages, solo at stage 2,
// 2-cycle trap window, watchdog limit 8).
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] stall_req, flush_req, stage_valid;
    logic       trap_req, solo_req, clog;
    logic [6:0] stall, flush;
    logic [1:0] state;
    logic       stall_timeout;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(
        .CORE(0), .NUM_STAGES(7), .SOLO_STAGE(2), .TRAP_FLUSH_CYCLES(2),
        .WDOG_WIDTH(16), .WDOG_LIMIT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .stall_req(stall_req), .flush_req(flush_req),
        .trap_req(trap_req), .solo_req(solo_req), .clog(clog),
        .stage_valid(stage_valid),
        .stall(stall), .flush(flush), .state(state), .stall_timeout(stall_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [6:0] es, input logic [6:0] ef,
                           input logic [1:0] est);
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".flush"}, 32'(flush), 32'(ef));
        chk({tag, ".state"}, 32'(state), 32'(est));
    endtask

    initial begin
        reset = 1'b1; stall_req = 7'h7F; flush_req = '0; stage_valid = '0;
        trap_req = 1'b0; solo_req = 1'b0; clog = 1'b0;
        #2;
        chk_out("in_reset", 7'h00, 7'h00, 2'd0);
        tick(); stall_req = '0;
        tick(); reset = 1'b0;
        tick(); tick(); #1;
        chk_out("idle", 7'h00, 7'h00, 2'd0);
        chk("idle.timeout", 32'(stall_timeout), 32'd0);

        // Trap: two-cycle full flush window
        trap_req = 1'b1; #1;
        chk_out("trap0", 7'h00, 7'h7F, 2'd0);
        tick(); trap_req = 1'b0; #1;
        chk_out("trap1", 7'h00, 7'h7F, 2'd1);
        tick(); #1;
        chk_out("trap2", 7'h00, 7'h00, 2'd0);

        // Trap outranks clog
        clog = 1'b1; trap_req = 1'b1; #1;
        chk_out("trapclog0", 7'h00, 7'h7F, 2'd0);
        tick(); trap_req = 1'b0; #1;
        chk_out("trapclog1", 7'h00, 7'h7F, 2'd1);
        tick(); #1;
        chk_out("trapclog2", 7'h7F, 7'h00, 2'd0);
        clog = 1'b0;

        // Stage-3 hazard, then a blocked and an honoured redirect
        stall_req = 7'b0001000; #1;
        chk_out("stall3", 7'b0001111, 7'b0010000, 2'd0);
        flush_req = 7'b0000010; #1;
        chk_out("redir_blocked", 7'b0001111, 7'b0010000, 2'd0);
        tick(); stall_req = '0; #1;
        chk_out("redir_ok", 7'b0000000, 7'b0000011, 2'd0);
        flush_req = 7'b0100010; #1;
        chk_out("redir_multi", 7'b0000000, 7'b0111111, 2'd0);
        clog = 1'b1; #1;
        chk_out("clog_over_redir", 7'h7F, 7'h00, 2'd0);
        clog = 1'b0; flush_req = '0;
        tick();

        // Solo drain
        solo_req = 1'b1; stage_valid = 7'b0110100; #1;
        chk_out("solo_req", 7'b0000111, 7'b0001000, 2'd0);
        tick(); #1;
        chk_out("solo_drain", 7'b0000111, 7'b0001000, 2'd2);
        stage_valid = 7'b0000100; #1;
        chk_out("solo_release", 7'b0000000, 7'b0000000, 2'd2);
        tick(); solo_req = 1'b0; #1;
        chk_out("solo_pass", 7'b0000000, 7'b0000000, 2'd3);
        tick(); #1;
        chk_out("solo_done", 7'b0000000, 7'b0000000, 2'd0);

        // Solo with empty older stages goes straight to pass
        solo_req = 1'b1; #1;
        chk_out("solo_nostall", 7'b0000000, 7'b0000000, 2'd0);
        tick(); solo_req = 1'b0; #1;
        chk_out("solo_direct", 7'b0000000, 7'b0000000, 2'd3);
        tick();

        // Trap aborts a solo drain
        solo_req = 1'b1; stage_valid = 7'b0110100;
        tick(); #1;
        chk("abort.pre_state", 32'(state), 32'd2);
        trap_req = 1'b1; #1;
        chk_out("abort_trap", 7'h00, 7'h7F, 2'd2);
        tick(); trap_req = 1'b0; solo_req = 1'b0; #1;
        chk_out("abort_flush", 7'h00, 7'h7F, 2'd1);
        tick(); #1;
        chk_out("abort_idle", 7'h00, 7'h00, 2'd0);
        stage_valid = '0;

        // Watchdog: 8 stalled cycles sets the sticky flag
        clog = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("wdog7", 32'(stall_timeout), 32'd0);
        tick();
        chk("wdog8", 32'(stall_timeout), 32'd1);
        clog = 1'b0;
        tick(); #1;
        chk("wdog_sticky", 32'(stall_timeout), 32'd1);
        chk("wdog_stall_free", 32'(stall), 32'd0);
        reset = 1'b1; #1;
        chk("wdog_reset", 32'(stall_timeout), 32'd0);
        chk_out("final_reset", 7'h00, 7'h00, 2'd0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
